// File: rtl/scu_idx_sequencer.sv
// rtl/scu_idx_sequencer.sv - walks every (out_idx, in_idx) channel pair of a layer
// with a valid/ready handshake, feeding scu_mapper.
module scu_idx_sequencer #(
   parameter int IDX_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [IDX_WIDTH-1:0]   cfg_out_ch,
   input  logic [IDX_WIDTH-1:0]   cfg_in_ch,
   output logic [IDX_WIDTH-1:0]   out_ch,
   output logic [IDX_WIDTH-1:0]   in_ch,
   output logic [IDX_WIDTH-1:0]   out_idx,
   output logic [IDX_WIDTH-1:0]   in_idx,
   output logic                   idx_valid,
   input  logic                   idx_ready,
   output logic                   idx_last,
   output logic [2*IDX_WIDTH-1:0] beat_cnt,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [IDX_WIDTH-1:0]   IDX_ONE  = IDX_WIDTH'(1);
   localparam logic [2*IDX_WIDTH-1:0] BEAT_ONE = (2*IDX_WIDTH)'(1);

   state_t state, state_nxt;
   logic   launch;
   logic   xfer;
   logic   in_wrap;
   logic   last_pair;

   // in_ch >= 1 whenever RUN is reachable, so in_ch-1 cannot underflow there.
   assign in_wrap   = (in_idx == in_ch - IDX_ONE);
   assign last_pair = in_wrap && (out_idx == out_ch - IDX_ONE);

   assign launch    = (state == IDLE) && start && !abort;
   assign idx_valid = (state == RUN);
   assign idx_last  = (state == RUN) && last_pair;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_comb begin
      state_nxt = state;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            if (launch) begin
               if (cfg_out_ch == '0 || cfg_in_ch == '0) state_nxt = DONE;
               else                                    state_nxt = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (idx_ready) begin
               xfer = 1'b1;
               if (last_pair) state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Abort suppresses xfer above, so an aborted beat never reaches the counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_ch   <= '0;
         in_ch    <= '0;
         out_idx  <= '0;
         in_idx   <= '0;
         beat_cnt <= '0;
      end else if (launch) begin
         out_ch   <= cfg_out_ch;
         in_ch    <= cfg_in_ch;
         out_idx  <= '0;
         in_idx   <= '0;
         beat_cnt <= '0;
      end else if (xfer) begin
         beat_cnt <= beat_cnt + BEAT_ONE;
         if (in_wrap) begin
            in_idx  <= '0;
            out_idx <= out_idx + IDX_ONE;
         end else begin
            in_idx  <= in_idx + IDX_ONE;
         end
      end
   end

endmodule

// File: tb/tb_scu_idx_sequencer.sv
// tb/tb_scu_idx_sequencer.sv - self-checking bench for scu_idx_sequencer.
module tb_scu_idx_sequencer;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic           abort;
   logic [W-1:0]   cfg_out_ch;
   logic [W-1:0]   cfg_in_ch;
   logic [W-1:0]   out_ch;
   logic [W-1:0]   in_ch;
   logic [W-1:0]   out_idx;
   logic [W-1:0]   in_idx;
   logic           idx_valid;
   logic           idx_ready;
   logic           idx_last;
   logic [2*W-1:0] beat_cnt;
   logic           busy;
   logic           done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   scu_idx_sequencer #(.IDX_WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cfg_out_ch (cfg_out_ch),
      .cfg_in_ch  (cfg_in_ch),
      .out_ch     (out_ch),
      .in_ch      (in_ch),
      .out_idx    (out_idx),
      .in_idx     (in_idx),
      .idx_valid  (idx_valid),
      .idx_ready  (idx_ready),
      .idx_last   (idx_last),
      .beat_cnt   (beat_cnt),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      int oc;
      int ic;
      int beats;
      bit toggle;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic launch(input int oc, input int ic);
      cfg_out_ch = W'(oc);
      cfg_in_ch  = W'(ic);
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      // later cfg changes must not disturb the latched counts
      cfg_out_ch = 16'hBEEF;
      cfg_in_ch  = 16'h0000;
   endtask

   task automatic run_walk(input int oc, input int ic, input int exp_beats, input bit toggle);
      int  o = 0, i = 0, beats = 0, cyc = 0;
      bit  rdy;
      logic [2*W+1:0] exp_pay;
      launch(oc, ic);
      if (exp_beats == 0) begin
         chk("zero_valid", idx_valid, 0);
         chk("zero_done", done, 1);
         chk("zero_beats", beat_cnt, 0);
         @(negedge clk);
         chk("zero_done_clear", {done, busy, idx_valid}, 0);
         return;
      end
      while (beats < exp_beats && cyc < 6000) begin
         exp_pay = {1'b1, 1'(o == oc-1 && i == ic-1), W'(o), W'(i)};
         chk($sformatf("pair%0d", beats), {idx_valid, idx_last, out_idx, in_idx}, exp_pay);
         rdy = toggle ? (cyc % 2 == 0) : 1'b1;
         idx_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) begin
            beats++;
            if (i == ic-1) begin
               i = 0;
               o++;
            end else begin
               i++;
            end
         end
      end
      idx_ready = 1'b0;
      chk("walk_timeout", beats, exp_beats);
      if (!toggle) chk("walk_cycles", cyc, exp_beats);
      chk("end_valid", idx_valid, 0);
      chk("end_done", done, 1);
      chk("end_beats", beat_cnt, exp_beats);
      chk("end_ch", {out_ch, in_ch}, {W'(oc), W'(ic)});
      chk("end_idx", {out_idx, in_idx}, {W'(oc), W'(0)});
      @(negedge clk);
      chk("post_done", {done, busy, idx_valid}, 0);
      chk("post_beats", beat_cnt, exp_beats);
   endtask

   initial begin
      vecs[0] = '{2, 3, 6, 1'b0};
      vecs[1] = '{1, 1, 1, 1'b0};
      vecs[2] = '{3, 1, 3, 1'b0};
      vecs[3] = '{1, 4, 4, 1'b1};
      vecs[4] = '{36, 36, 1296, 1'b1};
      vecs[5] = '{0, 5, 0, 1'b0};
      vecs[6] = '{5, 0, 0, 1'b0};
      vecs[7] = '{4, 2, 8, 1'b1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; idx_ready = 1'b0;
      cfg_out_ch = '0; cfg_in_ch = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", {idx_valid, idx_last, done, busy, out_idx, in_idx, out_ch, in_ch, beat_cnt}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 8; v++)
         run_walk(vecs[v].oc, vecs[v].ic, vecs[v].beats, vecs[v].toggle);

      // single beat with start held through RUN and DONE
      cfg_out_ch = 16'd1; cfg_in_ch = 16'd1; start = 1'b1; idx_ready = 1'b1;
      @(negedge clk);
      chk("one_beat", {idx_valid, idx_last, out_idx, in_idx}, {2'b11, 32'd0});
      @(negedge clk);
      chk("one_done", {done, idx_valid}, 2'b10);
      @(negedge clk);
      chk("one_idle", {done, busy, idx_valid}, 0);
      chk("one_beats", beat_cnt, 1);
      start = 1'b0; idx_ready = 1'b0;
      @(negedge clk);
      chk("one_no_restart", busy, 0);

      // abort coincident with the 5th transfer
      launch(4, 4);
      idx_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_pair", {idx_valid, out_idx, in_idx}, {1'b1, 16'd1, 16'd0});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; idx_ready = 1'b0;
      chk("abort_state", {done, busy, idx_valid}, 0);
      chk("abort_beats", beat_cnt, 4);
      chk("abort_idx", {out_idx, in_idx}, {16'd1, 16'd0});
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 0);

      // abort and start together in IDLE: stay idle, nothing latched
      cfg_out_ch = 16'd3; cfg_in_ch = 16'd3; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start_idle", {busy, idx_valid, done}, 0);
      chk("abort_start_hold", {beat_cnt, out_ch}, {32'd4, 16'd4});

      // asynchronous reset mid-walk
      launch(8, 8);
      idx_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_beats", beat_cnt, 10);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {idx_valid, idx_last, done, busy, out_idx, in_idx, out_ch, in_ch, beat_cnt}, 0);
      idx_ready = 1'b0;
      @(negedge clk);
      chk("reset_no_done", {done, busy}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_walk(8, 8, 64, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
